// File: rtl/edabk_uart_tx.sv
// EDABK UART transmit engine: pops bytes from the TX FIFO and serializes them LSB-first.
// Optional parity bit is compiled in with `define CFG_UART_TX_PARITY_EN.
module edabk_uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tx_enable,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  stop_bits_2,
    input  logic                  parity_odd,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  fifo_read,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef CFG_UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DIV_WIDTH-1:0]  baud_cnt_q, baud_cnt_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  pop_ok;
    logic                  tick;
    logic                  load;

`ifdef CFG_UART_TX_PARITY_EN
    logic                  par_q, par_d;
`else
    logic                  unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    // Next-state, counters, pop strobe and the registered line/done values
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        div_d      = div_q;
        stop2_d    = stop2_q;
`ifdef CFG_UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        fifo_read  = 1'b0;
        load       = 1'b0;
        tx_d       = 1'b1;
        done_d     = 1'b0;

        // Reset gates the pop so the FIFO never loses a word while held in reset
        pop_ok = reset_n & tx_enable & ~fifo_empty;
        tick   = (baud_cnt_q == '0);

        if (state_q != ST_IDLE && !tick) begin
            baud_cnt_d = baud_cnt_q - 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (pop_ok) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d    = ST_DATA;
                    baud_cnt_d = div_q;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d    = shift_q >> 1;
                    baud_cnt_d = div_q;
                    if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
`ifdef CFG_UART_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef CFG_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d    = ST_STOP;
                    baud_cnt_d = div_q;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt_q == CW'(stop2_q)) begin
                        if (pop_ok) begin
                            load = 1'b1;
                        end else begin
                            state_d   = ST_IDLE;
                            bit_cnt_d = '0;
                        end
                    end else begin
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        baud_cnt_d = div_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pop, capture the head word and latch this frame's configuration
        if (load) begin
            fifo_read  = 1'b1;
            state_d    = ST_START;
            shift_d    = fifo_read_data;
            div_d      = baud_div;
            baud_cnt_d = baud_div;
            stop2_d    = stop_bits_2;
            bit_cnt_d  = '0;
`ifdef CFG_UART_TX_PARITY_EN
            par_d      = (^fifo_read_data) ^ parity_odd;
`endif
        end

        // Line level follows the state being entered next cycle
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef CFG_UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = 1'b1;
        endcase

        // Next cycle is the final clock of the last stop bit
        done_d = (state_d == ST_STOP) && (baud_cnt_d == '0) &&
                 (bit_cnt_d == CW'(stop2_d));
    end

    // State and datapath registers with asynchronous reset to an idle line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            div_q      <= '0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
`ifdef CFG_UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
`ifdef CFG_UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_done = done_q;
    // Busy covers the pop cycle itself, so it is continuous across back-to-back frames
    assign busy    = (state_q != ST_IDLE) | fifo_read;

endmodule
